// File: rtl/acc_core.sv
// acc_core: multicycle accumulator CPU core (AC/PC/MAR/MBR/IR) with a single ready/valid memory port.
// Latency: 2 cycles register-only, 3 STORE, 4 memory-read ALU ops; each memory wait cycle adds 1.
// Backpressure: mem_req/mem_we/mem_addr/mem_wdata hold stable until mem_ready; optional MUL via ACC_CORE_MUL_EN.
module acc_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ac,
  output logic              halted,
  output logic              retire
);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_MEMRD  = 3'd3;
  localparam logic [2:0] S_MEMWR  = 3'd4;
  localparam logic [2:0] S_EXEC   = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  logic [2:0]        state;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mbr;
  logic [DATA_W-1:0] ir;
  logic              retire_q;

  logic [3:0]        op;
  logic [ADDR_W-1:0] opnd;
  logic [DATA_W-1:0] opnd_ext;
  logic              is_rd;
  logic [DATA_W-1:0] alu;
  logic              unused_ir;

  // Middle IR bits carry no meaning; folding them here keeps the whole IR visibly consumed.
  assign unused_ir = ^ir;

  assign op       = ir[DATA_W-1 -: 4];
  assign opnd     = ir[ADDR_W-1:0];
  assign opnd_ext = {{(DATA_W-ADDR_W){1'b0}}, opnd};

  // Opcodes that need an operand read from memory before EXEC.
  always_comb begin
    is_rd = 1'b0;
    case (op)
      4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: is_rd = 1'b1;
`ifdef ACC_CORE_MUL_EN
      4'hE: is_rd = 1'b1;
`endif
      default: is_rd = 1'b0;
    endcase
  end

  // EXEC result from AC and the fetched operand in MBR; arithmetic wraps modulo 2^DATA_W.
  always_comb begin
    alu = ac;
    case (op)
      4'h1: alu = mbr;
      4'h3: alu = ac + mbr;
      4'h4: alu = ac - mbr;
      4'h5: alu = ac & mbr;
      4'h6: alu = ac | mbr;
      4'h7: alu = ac ^ mbr;
`ifdef ACC_CORE_MUL_EN
      4'hE: alu = ac * mbr;
`endif
      default: alu = ac;
    endcase
  end

  // FSM and architectural registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_RESET;
      pc       <= RESET_PC;
      ac       <= '0;
      mar      <= '0;
      mbr      <= '0;
      ir       <= '0;
      retire_q <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      case (state)
        S_RESET: state <= S_FETCH;
        S_FETCH: begin
          if (mem_ready) begin
            ir    <= mem_rdata;
            pc    <= pc + ADDR_W'(1);
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (op == 4'hF) begin
            state    <= S_HALT;
            retire_q <= 1'b1;
          end else if (op == 4'h2) begin
            mar   <= opnd;
            state <= S_MEMWR;
          end else if (is_rd) begin
            mar   <= opnd;
            state <= S_MEMRD;
          end else begin
            // Register-only ops complete here; jump tests see AC before this instruction.
            state    <= S_FETCH;
            retire_q <= 1'b1;
            case (op)
              4'h8: pc <= opnd;
              4'h9: if (ac == '0) pc <= opnd;
              4'hA: if (ac[DATA_W-1]) pc <= opnd;
              4'hB: ac <= opnd_ext;
              4'hC: ac <= {ac[DATA_W-2:0], 1'b0};
              4'hD: ac <= {1'b0, ac[DATA_W-1:1]};
              default: ;
            endcase
          end
        end
        S_MEMRD: begin
          if (mem_ready) begin
            mbr   <= mem_rdata;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          ac       <= alu;
          state    <= S_FETCH;
          retire_q <= 1'b1;
        end
        S_MEMWR: begin
          if (mem_ready) begin
            state    <= S_FETCH;
            retire_q <= 1'b1;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_RESET;
      endcase
    end
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    mem_req   = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    mem_we    = (state == S_MEMWR);
    mem_addr  = (state == S_FETCH) ? pc : mar;
    mem_wdata = ac;
    halted    = (state == S_HALT);
    retire    = retire_q;
  end

endmodule

// File: tb/tb_acc_core.sv
// tb_acc_core: directed test of acc_core with a tb-side memory model and a second core at RESET_PC=0xFFF.
// Latency: checks fetch timing, wait states, reset abandonment, program results and retire counts.
// Backpressure: mem_ready of the main core is driven from the stimulus to insert wait states.
module tb_acc_core;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        mem_req, mem_we, halted, retire;
  logic [11:0] mem_addr, pc;
  logic [15:0] mem_wdata, mem_rdata, ac;

  logic        mem_req2, mem_we2, halted2, retire2;
  logic [11:0] mem_addr2, pc2;
  logic [15:0] mem_wdata2, ac2;

  logic [15:0] mem [0:4095];
  logic        ld_en, ld_clr;
  logic [11:0] ld_addr;
  logic [15:0] ld_data;

  logic [12:0] txlog [$];
  int          ret_cnt;
  int          halt_req_cnt;

  int          n_chk;
  int          n_fail;
  int          r0, n0, rd_cnt;
  logic        found;
  logic [12:0] exp_tx [5];

  acc_core #(.DATA_W(16), .ADDR_W(12), .RESET_PC(12'h000)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(rdy), .pc(pc), .ac(ac),
    .halted(halted), .retire(retire)
  );

  acc_core #(.DATA_W(16), .ADDR_W(12), .RESET_PC(12'hFFF)) dut2 (
    .clk(clk), .rst(rst), .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(16'h0000), .mem_ready(1'b1), .pc(pc2), .ac(ac2),
    .halted(halted2), .retire(retire2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  // Memory model: loader port during reset, DUT writes otherwise; logs completed transactions.
  always @(posedge clk) begin
    if (ld_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 16'h0000;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (mem_req && mem_we && rdy) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (!rst) begin
      if (mem_req && rdy) txlog.push_back({mem_we, mem_addr});
      if (retire) ret_cnt <= ret_cnt + 1;
      if (halted && mem_req) halt_req_cnt <= halt_req_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic clear_mem;
    ld_clr = 1'b1;
    @(posedge clk); #1;
    ld_clr = 1'b0;
  endtask

  task automatic release_rst;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_until_halt(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    chk("halt_reached", 32'(halted), 32'h1);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; ret_cnt = 0; halt_req_cnt = 0;
    rst = 1'b1; rdy = 1'b1; ld_en = 1'b0; ld_clr = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values
    chk("rst_mem_req",   32'(mem_req),   32'h0);
    chk("rst_mem_we",    32'(mem_we),    32'h0);
    chk("rst_mem_addr",  32'(mem_addr),  32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_pc",        32'(pc),        32'h0);
    chk("rst_ac",        32'(ac),        32'h0);
    chk("rst_halted",    32'(halted),    32'h0);
    chk("rst_retire",    32'(retire),    32'h0);
    chk("rst_pc2",       32'(pc2),       32'hFFF);
    chk("rst_req2",      32'(mem_req2),  32'h0);
    chk("rst_we2",       32'(mem_we2),   32'h0);
    chk("rst_wdata2",    32'(mem_wdata2), 32'h0);

    // Program: LDI 5; ADD [0x100]; STORE [0x101]; HALT, with M[0x100]=7
    clear_mem;
    poke(12'h000, 16'hB005);
    poke(12'h001, 16'h3100);
    poke(12'h002, 16'h2101);
    poke(12'h003, 16'hF000);
    poke(12'h100, 16'h0007);
    release_rst;
    r0 = ret_cnt;
    chk("first_req_not_yet", 32'(mem_req), 32'h0);
    @(posedge clk); #1;
    chk("first_fetch_req",  32'(mem_req),   32'h1);
    chk("first_fetch_addr", 32'(mem_addr),  32'h000);
    chk("wrap_fetch_addr",  32'(mem_addr2), 32'hFFF);
    @(posedge clk); #1;
    chk("wrap_pc2",         32'(pc2),       32'h000);
    @(posedge clk); #1;
    chk("wrap_next_fetch",  32'(mem_addr2), 32'h000);
    chk("wrap_req2",        32'(mem_req2),  32'h1);
    chk("nop_retire2",      32'(retire2),   32'h1);
    chk("nop_ac2",          32'(ac2),       32'h0);
    chk("ldi_ac",           32'(ac),        32'h0005);
    run_until_halt(100);
    chk("prog_store",       32'(mem[12'h101]), 32'h000C);
    chk("prog_ac",          32'(ac),        32'h000C);
    repeat (5) @(negedge clk);
    chk("prog_retires",     32'(ret_cnt - r0), 32'd4);
    chk("halt_no_req",      32'(halt_req_cnt), 32'd0);
    chk("halt_req_low",     32'(mem_req),   32'h0);
    chk("halted2_low",      32'(halted2),   32'h0);

    // Fetch wait states at PC=0x010
    rst = 1'b1;
    clear_mem;
    poke(12'h000, 16'h8010);
    poke(12'h010, 16'h0000);
    poke(12'h011, 16'hF000);
    release_rst;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 12'h010) begin
        found = 1'b1;
        rdy = 1'b0;
      end
    end
    chk("wait_fetch_found", 32'(found), 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wait_req",  32'(mem_req),  32'h1);
      chk("wait_addr", 32'(mem_addr), 32'h010);
      chk("wait_pc",   32'(pc),       32'h010);
    end
    rdy = 1'b1;
    @(posedge clk); #1;
    chk("wait_pc_done", 32'(pc), 32'h011);
    run_until_halt(100);
    chk("wait_end_pc", 32'(pc), 32'h012);

    // Reset during a MEMRD wait state
    rst = 1'b1;
    clear_mem;
    poke(12'h000, 16'hB005);
    poke(12'h001, 16'h3100);
    poke(12'h100, 16'h0007);
    release_rst;
    n0 = txlog.size();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_req && !mem_we && mem_addr == 12'h100) begin
        found = 1'b1;
        rdy = 1'b0;
      end
    end
    chk("memrd_found", 32'(found), 32'h1);
    @(posedge clk); #2;
    chk("memrd_wait_req", 32'(mem_req), 32'h1);
    chk("memrd_wait_ac",  32'(ac),      32'h0005);
    rst = 1'b1;
    #1;
    chk("arst_req",  32'(mem_req),  32'h0);
    chk("arst_pc",   32'(pc),       32'h0);
    chk("arst_ac",   32'(ac),       32'h0);
    chk("arst_addr", 32'(mem_addr), 32'h0);
    @(negedge clk);
    rdy = 1'b1;
    rst = 1'b0;
    chk("arst_rel_req", 32'(mem_req), 32'h0);
    @(posedge clk); #1;
    chk("arst_refetch_req",  32'(mem_req),  32'h1);
    chk("arst_refetch_addr", 32'(mem_addr), 32'h000);
    chk("arst_tx_count", 32'(txlog.size() - n0), 32'd2);

    // SUB to 0xFFFF, JZ not taken, JN taken
    rst = 1'b1;
    clear_mem;
    poke(12'h000, 16'h4100);
    poke(12'h001, 16'h9030);
    poke(12'h002, 16'hA020);
    poke(12'h020, 16'hF000);
    poke(12'h030, 16'hF000);
    poke(12'h100, 16'h0001);
    release_rst;
    n0 = txlog.size();
    run_until_halt(100);
    chk("sub_ac",  32'(ac), 32'hFFFF);
    chk("jn_pc",   32'(pc), 32'h021);
    chk("jn_tx_count", 32'(txlog.size() - n0), 32'd5);
    exp_tx[0] = 13'h0000; exp_tx[1] = 13'h0100; exp_tx[2] = 13'h0001;
    exp_tx[3] = 13'h0002; exp_tx[4] = 13'h0020;
    for (int i = 0; i < 5; i++) begin
      if (n0 + i < txlog.size()) chk("jump_tx", 32'(txlog[n0 + i]), 32'(exp_tx[i]));
    end

    // MUL: LDI 0x300; MUL [0x100]; STORE [0x102]; LDI 0x300; MUL [0x101]; HALT
    rst = 1'b1;
    clear_mem;
    poke(12'h000, 16'hB300);
    poke(12'h001, 16'hE100);
    poke(12'h002, 16'h2102);
    poke(12'h003, 16'hB300);
    poke(12'h004, 16'hE101);
    poke(12'h005, 16'hF000);
    poke(12'h100, 16'h0100);
    poke(12'h101, 16'h0002);
    release_rst;
    n0 = txlog.size();
    r0 = ret_cnt;
    run_until_halt(200);
    @(negedge clk);
    chk("mul_retires", 32'(ret_cnt - r0), 32'd6);
    rd_cnt = 0;
    for (int i = n0; i < txlog.size(); i++) begin
      if (txlog[i] == 13'h0100 || txlog[i] == 13'h0101) rd_cnt++;
    end
`ifdef ACC_CORE_MUL_EN
    chk("mul_trunc",     32'(mem[12'h102]), 32'h0000);
    chk("mul_ac",        32'(ac),           32'h0600);
    chk("mul_reads",     32'(rd_cnt),       32'd2);
    chk("mul_tx_count",  32'(txlog.size() - n0), 32'd9);
`else
    chk("mulnop_store",  32'(mem[12'h102]), 32'h0300);
    chk("mulnop_ac",     32'(ac),           32'h0300);
    chk("mulnop_reads",  32'(rd_cnt),       32'd0);
    chk("mulnop_tx_count", 32'(txlog.size() - n0), 32'd7);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
